// File: rtl/end_module_pkg.sv
// Shared types and constants for the end_module operand-select + ALU stage.
package end_module_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_MUL  = 2'd2,
        ALU_RSVD = 2'd3
    } alu_op_e;

    localparam int OP_COUNT_W = 7;

endpackage

// File: rtl/end_module_operand_mux4.sv
// Combinational 4:1 operand select; an unselected input never reaches x.
module operand_mux4 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] x
);

    always_comb begin
        x = i0;
        case (sel)
            2'd0:    x = i0;
            2'd1:    x = i1;
            2'd2:    x = i2;
            2'd3:    x = i3;
            default: x = i0;
        endcase
    end

endmodule

// File: rtl/end_module.sv
// Registered operand-select + ALU stage: one result per accepted op, error flag
// for the reserved opcode, and a wrapping count of successful ops.
module end_module
    import end_module_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      i0,
    input  logic [WIDTH-1:0]      i1,
    input  logic [WIDTH-1:0]      i2,
    input  logic [WIDTH-1:0]      i3,
    input  logic                  s1,
    input  logic                  s0,
    input  logic [WIDTH-1:0]      z,
    input  logic [1:0]            alu_control,
    output logic                  out_valid,
    output logic [2*WIDTH-1:0]    y,
    output logic                  err,
    output logic [OP_COUNT_W-1:0] op_count
);

    localparam int YW = 2 * WIDTH;

    logic [WIDTH-1:0]      x;
    logic [YW-1:0]         x_ext;
    logic [YW-1:0]         z_ext;
    alu_op_e               alu_op;

    logic                  out_valid_d, out_valid_q;
    logic                  err_d, err_q;
    logic [YW-1:0]         y_d, y_q;
    logic [OP_COUNT_W-1:0] op_count_d, op_count_q;

    operand_mux4 #(.WIDTH(WIDTH)) u_mux (
        .i0  (i0),
        .i1  (i1),
        .i2  (i2),
        .i3  (i3),
        .sel ({s1, s0}),
        .x   (x)
    );

    assign x_ext  = {{WIDTH{1'b0}}, x};
    assign z_ext  = {{WIDTH{1'b0}}, z};
    assign alu_op = alu_op_e'(alu_control);

    always_comb begin
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        y_d         = y_q;
        op_count_d  = op_count_q;
        if (in_valid) begin
            out_valid_d = 1'b1;
            case (alu_op)
                ALU_ADD: begin
                    y_d        = x_ext + z_ext;
                    op_count_d = op_count_q + 1'b1;
                end
                ALU_SUB: begin
                    y_d        = x_ext - z_ext;
                    op_count_d = op_count_q + 1'b1;
                end
                ALU_MUL: begin
                    // Both operands are zero-extended, so the full product fits.
                    y_d        = x_ext * z_ext;
                    op_count_d = op_count_q + 1'b1;
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            y_q         <= '0;
            op_count_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            y_q         <= y_d;
            op_count_q  <= op_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign y         = y_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_end_module.sv
// Bench for end_module: spec vector table, corner sequences, random ops vs a reference model.
module tb_end_module;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  i0, i1, i2, i3;
    logic        s1, s0;
    logic [7:0]  z;
    logic [1:0]  alu_control;
    logic        out_valid;
    logic [15:0] y;
    logic        err;
    logic [6:0]  op_count;

    int n_checks;
    int n_errors;

    // Reference model state: what the outputs should show after each edge.
    int model_y;
    int model_cnt;
    bit model_valid;
    bit model_err;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] i0, i1, i2, i3;
        logic [7:0] z;
        logic [1:0] op;
        logic [15:0] exp_y;
        logic        exp_err;
        bit          idle_after;
    } vec_t;

    vec_t vecs[8];

    end_module #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .i0          (i0),
        .i1          (i1),
        .i2          (i2),
        .i3          (i3),
        .s1          (s1),
        .s0          (s0),
        .z           (z),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .y           (y),
        .err         (err),
        .op_count    (op_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_result(input int op, input int x, input int b);
        case (op)
            0:       return x + b;
            1:       return (x + 65536 - b) % 65536;
            default: return x * b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("y_model", {16'h0, y}, model_y[31:0]);
        check("out_valid_model", {31'h0, out_valid}, {31'h0, model_valid});
        check("err_model", {31'h0, err}, {31'h0, model_err});
        check("op_count_model", {25'h0, op_count}, model_cnt[31:0]);
    endtask

    // One clock: advance the model with the inputs the DUT sampled, then compare.
    task automatic step();
        int operands[4];
        int sel;
        @(posedge clk);
        operands[0] = int'(i0); operands[1] = int'(i1);
        operands[2] = int'(i2); operands[3] = int'(i3);
        sel = int'({s1, s0});
        if (reset) begin
            model_y = 0; model_cnt = 0; model_valid = 0; model_err = 0;
        end else if (in_valid) begin
            model_valid = 1;
            if (alu_control == 2'd3) begin
                model_err = 1;
            end else begin
                model_err = 0;
                model_y   = ref_result(int'(alu_control), operands[sel], int'(z));
                model_cnt = (model_cnt + 1) % 128;
            end
        end else begin
            model_valid = 0;
            model_err   = 0;
        end
        #1;
        check_model();
    endtask

    task automatic drive_op(input logic [1:0] sel, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic [7:0] a3,
                            input logic [7:0] b, input logic [1:0] op);
        in_valid = 1'b1;
        {s1, s0} = sel;
        i0 = a0; i1 = a1; i2 = a2; i3 = a3;
        z = b;
        alu_control = op;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        i0 = 8'($urandom); i1 = 8'($urandom); i2 = 8'($urandom); i3 = 8'($urandom);
        z = 8'($urandom);
        alu_control = 2'($urandom);
        {s1, s0} = 2'($urandom);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_y"}, {16'h0, y}, 32'h0);
        check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, "_err"}, {31'h0, err}, 32'h0);
        check({tag, "_op_count"}, {25'h0, op_count}, 32'h0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        model_y = 0; model_cnt = 0; model_valid = 0; model_err = 0;
        reset = 1'b1;
        drive_idle();

        vecs[0] = '{2'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 2'd0, 16'd15, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 2'd0, 16'd25, 1'b0, 1'b0};
        vecs[2] = '{2'd2, 8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 2'd0, 16'd35, 1'b0, 1'b0};
        vecs[3] = '{2'd3, 8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 2'd0, 16'd45, 1'b0, 1'b0};
        vecs[4] = '{2'd3, 8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 2'd3, 16'd45, 1'b1, 1'b1};
        vecs[5] = '{2'd0, 8'd3,  8'd0,  8'd0,  8'd0,  8'd5, 2'd1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6] = '{2'd0, 8'd255, 8'd0, 8'd0,  8'd0,  8'd255, 2'd2, 16'hFE01, 1'b0, 1'b0};
        vecs[7] = '{2'd0, 8'd255, 8'd0, 8'd0,  8'd0,  8'd255, 2'd0, 16'h01FE, 1'b0, 1'b0};

        #2;
        check_zero("power_on_reset");
        step();
        step();
        @(negedge clk);
        reset = 1'b0;

        // Spec vectors: mux/add sweep, reserved opcode, sub/mul/add edge values
        for (int k = 0; k < 8; k++) begin
            int cnt_before;
            cnt_before = model_cnt;
            drive_op(vecs[k].sel, vecs[k].i0, vecs[k].i1, vecs[k].i2, vecs[k].i3,
                     vecs[k].z, vecs[k].op);
            step();
            check($sformatf("vec%0d_y", k), {16'h0, y}, {16'h0, vecs[k].exp_y});
            check($sformatf("vec%0d_err", k), {31'h0, err}, {31'h0, vecs[k].exp_err});
            check($sformatf("vec%0d_out_valid", k), {31'h0, out_valid}, 32'h1);
            if (vecs[k].exp_err)
                check($sformatf("vec%0d_cnt_hold", k), {25'h0, op_count}, cnt_before[31:0]);
            if (vecs[k].idle_after) begin
                drive_idle();
                step();
                check($sformatf("vec%0d_idle_err", k), {31'h0, err}, 32'h0);
                check($sformatf("vec%0d_idle_valid", k), {31'h0, out_valid}, 32'h0);
                check($sformatf("vec%0d_idle_y", k), {16'h0, y}, {16'h0, vecs[k].exp_y});
            end
        end

        // Asynchronous reset between edges
        drive_op(2'd1, 8'd7, 8'd9, 8'd0, 8'd0, 8'd4, 2'd2);
        step();
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        step();
        #4;
        reset = 1'b0;

        // Counter wrap: 128 back-to-back successful adds from reset
        for (int k = 0; k < 128; k++) begin
            drive_op(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 2'd0);
            step();
            if (k == 126) check("wrap_127", {25'h0, op_count}, 32'd127);
            if (k == 127) check("wrap_0", {25'h0, op_count}, 32'd0);
        end

        // Reset pulse while an op is being presented
        drive_op(2'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 2'd0);
        #4;
        reset = 1'b1;
        step();
        check("midreset_out_valid", {31'h0, out_valid}, 32'h0);
        #4;
        reset = 1'b0;
        step();
        check("midreset_first_count", {25'h0, op_count}, 32'd1);
        check("midreset_first_y", {16'h0, y}, 32'd9);

        // Randomized traffic including idle cycles and reserved opcodes
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) drive_idle();
            else drive_op(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                          8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
